// File: rtl/qpu_exu_alu_cmp_arb.sv
// rtl/qpu_exu_alu_cmp_arb.sv - round-robin arbiter and one-entry result stage for the shared ALU comparator
module qpu_exu_alu_cmp_arb #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            bjp_req_valid,
   output logic            bjp_req_ready,
   input  logic [XLEN-1:0] bjp_req_op1,
   input  logic [XLEN-1:0] bjp_req_op2,
   input  logic [3:0]      bjp_req_cmp,
   output logic            bjp_rsp_valid,
   input  logic            bjp_rsp_ready,
   output logic            bjp_rsp_res,
   input  logic            alu_req_valid,
   output logic            alu_req_ready,
   input  logic [XLEN-1:0] alu_req_op1,
   input  logic [XLEN-1:0] alu_req_op2,
   input  logic [3:0]      alu_req_cmp,
   output logic            alu_rsp_valid,
   input  logic            alu_rsp_ready,
   output logic            alu_rsp_res,
   output logic [XLEN-1:0] dp_op1,
   output logic [XLEN-1:0] dp_op2,
   output logic            dp_cmp_eq,
   output logic            dp_cmp_ne,
   output logic            dp_cmp_lt,
   output logic            dp_cmp_gt,
   input  logic            dp_cmp_res,
   output logic            illegal_op
);

   logic            last_grant;
   logic            rsp_vld;
   logic            rsp_owner;
   logic            rsp_res;

   logic            owner_ready;
   logic            can_accept;
   logic            grant_bjp;
   logic            grant_alu;
   logic            accept;
   logic [XLEN-1:0] sel_op1;
   logic [XLEN-1:0] sel_op2;
   logic [3:0]      sel_cmp;
   logic            one_hot;

   assign owner_ready = rsp_owner ? alu_rsp_ready : bjp_rsp_ready;
   assign can_accept  = !rsp_vld || owner_ready;

   // On contention the requester that was not granted last time wins.
   assign grant_bjp = can_accept && bjp_req_valid && (!alu_req_valid || last_grant);
   assign grant_alu = can_accept && alu_req_valid && (!bjp_req_valid || !last_grant);
   assign accept    = grant_bjp || grant_alu;

   assign bjp_req_ready = grant_bjp;
   assign alu_req_ready = grant_alu;

   always_comb begin
      sel_op1 = '0;
      sel_op2 = '0;
      sel_cmp = 4'b0000;
      if (grant_bjp) begin
         sel_op1 = bjp_req_op1;
         sel_op2 = bjp_req_op2;
         sel_cmp = bjp_req_cmp;
      end else if (grant_alu) begin
         sel_op1 = alu_req_op1;
         sel_op2 = alu_req_op2;
         sel_cmp = alu_req_cmp;
      end
   end

   assign one_hot = (sel_cmp != 4'b0000) && ((sel_cmp & (sel_cmp - 4'd1)) == 4'b0000);

   assign dp_op1    = sel_op1;
   assign dp_op2    = sel_op2;
   assign dp_cmp_eq = sel_cmp[0];
   assign dp_cmp_ne = sel_cmp[1];
   assign dp_cmp_lt = sel_cmp[2];
   assign dp_cmp_gt = sel_cmp[3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         rsp_vld    <= 1'b0;
         rsp_owner  <= 1'b0;
         rsp_res    <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         if (accept) begin
            rsp_vld    <= 1'b1;
            rsp_owner  <= grant_alu;
            rsp_res    <= one_hot && dp_cmp_res;
            last_grant <= grant_alu;
            if (!one_hot) begin
               illegal_op <= 1'b1;
            end
         end else if (owner_ready) begin
            rsp_vld <= 1'b0;
         end
      end
   end

   assign bjp_rsp_valid = rsp_vld && !rsp_owner;
   assign alu_rsp_valid = rsp_vld && rsp_owner;
   assign bjp_rsp_res   = bjp_rsp_valid && rsp_res;
   assign alu_rsp_res   = alu_rsp_valid && rsp_res;

endmodule

// File: tb/tb_qpu_exu_alu_cmp_arb.sv
// tb/tb_qpu_exu_alu_cmp_arb.sv - self-checking bench for qpu_exu_alu_cmp_arb
module tb_qpu_exu_alu_cmp_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bjp_req_valid = 1'b0, bjp_req_ready;
   logic [31:0] bjp_req_op1 = '0, bjp_req_op2 = '0;
   logic [3:0]  bjp_req_cmp = '0;
   logic        bjp_rsp_valid, bjp_rsp_ready = 1'b1, bjp_rsp_res;
   logic        alu_req_valid = 1'b0, alu_req_ready;
   logic [31:0] alu_req_op1 = '0, alu_req_op2 = '0;
   logic [3:0]  alu_req_cmp = '0;
   logic        alu_rsp_valid, alu_rsp_ready = 1'b1, alu_rsp_res;
   logic [31:0] dp_op1, dp_op2;
   logic        dp_cmp_eq, dp_cmp_ne, dp_cmp_lt, dp_cmp_gt;
   logic        dp_cmp_res;
   logic        illegal_op;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // external comparator seen by the arbiter
   assign dp_cmp_res = (dp_cmp_eq & (dp_op1 == dp_op2)) | (dp_cmp_ne & (dp_op1 != dp_op2)) |
                       (dp_cmp_lt & (dp_op1 <  dp_op2)) | (dp_cmp_gt & (dp_op1 >  dp_op2));

   qpu_exu_alu_cmp_arb #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .bjp_req_valid(bjp_req_valid), .bjp_req_ready(bjp_req_ready),
      .bjp_req_op1(bjp_req_op1), .bjp_req_op2(bjp_req_op2), .bjp_req_cmp(bjp_req_cmp),
      .bjp_rsp_valid(bjp_rsp_valid), .bjp_rsp_ready(bjp_rsp_ready), .bjp_rsp_res(bjp_rsp_res),
      .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
      .alu_req_op1(alu_req_op1), .alu_req_op2(alu_req_op2), .alu_req_cmp(alu_req_cmp),
      .alu_rsp_valid(alu_rsp_valid), .alu_rsp_ready(alu_rsp_ready), .alu_rsp_res(alu_rsp_res),
      .dp_op1(dp_op1), .dp_op2(dp_op2),
      .dp_cmp_eq(dp_cmp_eq), .dp_cmp_ne(dp_cmp_ne), .dp_cmp_lt(dp_cmp_lt), .dp_cmp_gt(dp_cmp_gt),
      .dp_cmp_res(dp_cmp_res), .illegal_op(illegal_op)
   );

   typedef struct {
      logic        who;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  cmp;
      logic        exp_res;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
      if ($countones(c) != 1) return 1'b0;
      if (c[0]) return a == b;
      if (c[1]) return a != b;
      if (c[2]) return a < b;
      return a > b;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bjp_req_valid = 1'b0;
      alu_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_single(input logic who, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] c, input logic exp);
      @(negedge clk);
      bjp_req_valid = !who; bjp_req_op1 = a; bjp_req_op2 = b; bjp_req_cmp = c;
      alu_req_valid = who;  alu_req_op1 = a; alu_req_op2 = b; alu_req_cmp = c;
      #1;
      chk("single_ready", {bjp_req_ready, alu_req_ready}, {!who, who});
      chk("single_dp_cmp", {dp_cmp_gt, dp_cmp_lt, dp_cmp_ne, dp_cmp_eq}, c);
      chk("single_dp_ops", {dp_op1, dp_op2}, {a, b});
      @(negedge clk);
      bjp_req_valid = 1'b0;
      alu_req_valid = 1'b0;
      #1;
      chk("single_rsp_valid", {bjp_rsp_valid, alu_rsp_valid}, {!who, who});
      chk("single_rsp_res", who ? alu_rsp_res : bjp_rsp_res, exp);
   endtask

   vec_t vt[6];
   logic b_pend, a_pend, mlast, eb, ea, free, saw_illegal, g;
   logic qb[$];
   logic qa[$];
   int cb, ca, prev;

   initial begin
      vt[0] = '{1'b0, 32'd5, 32'd5, 4'b0001, 1'b1};
      vt[1] = '{1'b1, 32'd3, 32'd7, 4'b0100, 1'b1};
      vt[2] = '{1'b0, 32'd7, 32'd3, 4'b0100, 1'b0};
      vt[3] = '{1'b1, 32'd9, 32'd2, 4'b1000, 1'b1};
      vt[4] = '{1'b0, 32'd4, 32'd4, 4'b0010, 1'b0};
      vt[5] = '{1'b1, 32'd1, 32'd2, 4'b0011, 1'b0};

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset_rsp_valid", {bjp_rsp_valid, alu_rsp_valid, bjp_rsp_res, alu_rsp_res}, 4'b0);
      chk("reset_ready", {bjp_req_ready, alu_req_ready}, 2'b0);
      chk("reset_dp", {dp_op1, dp_op2, dp_cmp_eq, dp_cmp_ne, dp_cmp_lt, dp_cmp_gt}, '0);
      chk("reset_illegal", illegal_op, 1'b0);
      rst_n = 1'b1;

      // table-driven single requests
      for (int i = 0; i < 5; i++) do_single(vt[i].who, vt[i].op1, vt[i].op2, vt[i].cmp, vt[i].exp_res);
      chk("illegal_before", illegal_op, 1'b0);
      do_single(vt[5].who, vt[5].op1, vt[5].op2, vt[5].cmp, vt[5].exp_res);
      chk("illegal_set", illegal_op, 1'b1);
      do_single(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0);
      for (int i = 0; i < 10; i++) begin
         logic [31:0] a, b;
         logic [3:0] c;
         a = $urandom_range(0, 5);
         b = $urandom_range(0, 5);
         c = 4'b0001 << $urandom_range(0, 3);
         do_single(i[0], a, b, c, ref_cmp(a, b, c));
      end
      chk("illegal_sticky", illegal_op, 1'b1);

      // contention from reset
      do_reset();
      bjp_req_op1 = 32'd5; bjp_req_op2 = 32'd5; bjp_req_cmp = 4'b0001;
      alu_req_op1 = 32'd3; alu_req_op2 = 32'd7; alu_req_cmp = 4'b0100;
      cb = 4; ca = 4; mlast = 1'b1; prev = 0;
      for (int cyc = 0; cyc <= 8; cyc++) begin
         @(negedge clk);
         bjp_req_valid = cb > 0;
         alu_req_valid = ca > 0;
         #1;
         if (cyc > 0) begin
            chk("cont_rsp_valid", {bjp_rsp_valid, alu_rsp_valid}, {prev == 0, prev == 1});
            chk("cont_rsp_res", bjp_rsp_res | alu_rsp_res, 1'b1);
         end
         if (cyc < 8) begin
            g = (cb > 0 && ca > 0) ? !mlast : (cb == 0);
            chk("cont_grant", {bjp_req_ready, alu_req_ready}, {!g, g});
            mlast = g;
            prev = g;
            if (g) ca--; else cb--;
         end
      end

      // owner back-pressure blocks the other requester
      @(negedge clk);
      bjp_rsp_ready = 1'b0;
      bjp_req_valid = 1'b1;
      #1;
      chk("bp_bjp_accept", bjp_req_ready, 1'b1);
      @(negedge clk);
      bjp_req_valid = 1'b0;
      alu_req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         chk("bp_alu_blocked", alu_req_ready, 1'b0);
         chk("bp_bjp_held", {bjp_rsp_valid, bjp_rsp_res}, 2'b11);
      end
      @(negedge clk);
      bjp_rsp_ready = 1'b1;
      #1;
      chk("bp_release_accept", alu_req_ready, 1'b1);
      @(negedge clk);
      alu_req_valid = 1'b0;
      #1;
      chk("bp_after", {bjp_rsp_valid, alu_rsp_valid, alu_rsp_res}, 3'b011);

      // reset while a BJP response is held
      @(negedge clk);
      bjp_rsp_ready = 1'b0;
      bjp_req_valid = 1'b1;
      @(negedge clk);
      bjp_req_valid = 1'b0;
      #1;
      chk("rst_mid_held", bjp_rsp_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_drop", {bjp_rsp_valid, alu_rsp_valid}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      bjp_rsp_ready = 1'b1;
      bjp_req_valid = 1'b1;
      alu_req_valid = 1'b1;
      #1;
      chk("rst_mid_first_grant", {bjp_req_ready, alu_req_ready}, 2'b10);

      // idle datapath
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bjp_req_valid = 1'b0;
         alu_req_valid = 1'b0;
         #1;
         chk("idle_dp_ops", {dp_op1, dp_op2}, 64'd0);
         chk("idle_dp_cmp", {dp_cmp_eq, dp_cmp_ne, dp_cmp_lt, dp_cmp_gt}, 4'd0);
         if (i > 0) chk("idle_rsp", {bjp_rsp_valid, alu_rsp_valid}, 2'b00);
      end

      // randomized traffic against a transaction-level model
      do_reset();
      mlast = 1'b1; b_pend = 1'b0; a_pend = 1'b0; saw_illegal = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (!b_pend && $urandom_range(0, 1) == 1) begin
            b_pend = 1'b1;
            bjp_req_op1 = $urandom_range(0, 7);
            bjp_req_op2 = $urandom_range(0, 7);
            bjp_req_cmp = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0001 << $urandom_range(0, 3);
         end
         if (!a_pend && $urandom_range(0, 1) == 1) begin
            a_pend = 1'b1;
            alu_req_op1 = $urandom_range(0, 7);
            alu_req_op2 = $urandom_range(0, 7);
            alu_req_cmp = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0001 << $urandom_range(0, 3);
         end
         bjp_req_valid = b_pend;
         alu_req_valid = a_pend;
         bjp_rsp_ready = $urandom_range(0, 3) != 0;
         alu_rsp_ready = $urandom_range(0, 3) != 0;
         #1;
         chk("rnd_bjp_rsp_valid", bjp_rsp_valid, qb.size() != 0);
         chk("rnd_alu_rsp_valid", alu_rsp_valid, qa.size() != 0);
         free = (qb.size() == 0 && qa.size() == 0) || (qb.size() != 0 && bjp_rsp_ready) ||
                (qa.size() != 0 && alu_rsp_ready);
         eb = free && b_pend && (!a_pend || mlast);
         ea = free && a_pend && (!b_pend || !mlast);
         chk("rnd_ready", {bjp_req_ready, alu_req_ready}, {eb, ea});
         chk("rnd_dp_op1", dp_op1, eb ? bjp_req_op1 : (ea ? alu_req_op1 : 32'd0));
         if (qb.size() != 0 && bjp_rsp_ready) chk("rnd_bjp_res", bjp_rsp_res, qb.pop_front());
         if (qa.size() != 0 && alu_rsp_ready) chk("rnd_alu_res", alu_rsp_res, qa.pop_front());
         if (eb) begin
            qb.push_back(ref_cmp(bjp_req_op1, bjp_req_op2, bjp_req_cmp));
            if ($countones(bjp_req_cmp) != 1) saw_illegal = 1'b1;
            b_pend = 1'b0;
            mlast = 1'b0;
         end
         if (ea) begin
            qa.push_back(ref_cmp(alu_req_op1, alu_req_op2, alu_req_cmp));
            if ($countones(alu_req_cmp) != 1) saw_illegal = 1'b1;
            a_pend = 1'b0;
            mlast = 1'b1;
         end
      end
      @(negedge clk);
      #1;
      chk("rnd_illegal", illegal_op, saw_illegal);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
